// File: rtl/nxn_game_ctrl.sv
// N x N, K-in-a-row two-player game controller with registered board and result.
// Latency: a move accepted at edge E0 is checked over E1..E4; next move earliest at E5.
// Backpressure: moves are only taken in WAIT states; illegal moves pulse moveErr, others are dropped.
module nxn_game_ctrl #(
  parameter  int N  = 3,
  parameter  int K  = 3,
  localparam int RW = (N < 2) ? 1 : $clog2(N),
  localparam int CW = $clog2(N*N+1)
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              isPlayer1Start,
  input  logic              playerWrite,
  input  logic [RW-1:0]     playerRow,
  input  logic [RW-1:0]     playerCol,
  output logic [2*N*N-1:0]  gBoard,
  output logic [2:0]        outputState,
  output logic              gameIsDone,
  output logic [1:0]        winner,
  output logic              moveErr,
  output logic [CW-1:0]     moveCount
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_WAIT_P1 = 3'b001,
    S_WAIT_P2 = 3'b010,
    S_CHECK   = 3'b011,
    S_DONE    = 3'b100
  } state_t;

  localparam logic [1:0] C_P1   = 2'b11;
  localparam logic [1:0] C_P2   = 2'b10;
  localparam logic [1:0] C_TIE  = 2'b01;
  localparam logic [1:0] C_NONE = 2'b00;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2*N*N-1:0]    r_board;
  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_winner;
  logic                r_move_err;
  logic [1:0]          r_dir;
  logic                r_win;
  logic [RW-1:0]       r_lrow;
  logic [RW-1:0]       r_lcol;
  logic [1:0]          r_lplayer;

  logic                w_in_range;
  logic                w_legal;
  logic [1:0]          w_mover;
  logic                w_accept;
  logic                w_err;
  logic                w_hit;
  logic                w_win_any;
  int                  w_dr;
  int                  w_dc;

  // Off-board coordinates read as empty, so they never extend a run.
  function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int rr, input int cc);
    logic [1:0] v;
    v = C_NONE;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (r == rr && c == cc) v = b[2*(r*N+c) +: 2];
    return v;
  endfunction

  // Contiguous run through (r0,c0) along (dr,dc), counting both senses plus the origin cell.
  function automatic int run_len(input logic [2*N*N-1:0] b, input int r0, input int c0,
                                 input logic [1:0] code, input int dr, input int dc);
    int   len;
    logic go_f;
    logic go_b;
    len  = 1;
    go_f = 1'b1;
    go_b = 1'b1;
    for (int i = 1; i < N; i++) begin
      if (go_f && cell_at(b, r0 + i*dr, c0 + i*dc) == code) len++;
      else go_f = 1'b0;
      if (go_b && cell_at(b, r0 - i*dr, c0 - i*dc) == code) len++;
      else go_b = 1'b0;
    end
    return len;
  endfunction

  // Move legality, mover code and the run check for the current direction.
  always_comb begin
    w_in_range = (int'(playerRow) < N) && (int'(playerCol) < N);
    w_legal    = playerWrite && w_in_range &&
                 (cell_at(r_board, int'(playerRow), int'(playerCol)) == C_NONE);
    w_mover    = (r_state == S_WAIT_P1) ? C_P1 : C_P2;
    w_dr = 0;
    w_dc = 1;
    case (r_dir)
      2'd1:    begin w_dr = 1; w_dc = 0;  end
      2'd2:    begin w_dr = 1; w_dc = 1;  end
      2'd3:    begin w_dr = 1; w_dc = -1; end
      default: begin w_dr = 0; w_dc = 1;  end
    endcase
    w_hit     = run_len(r_board, int'(r_lrow), int'(r_lcol), r_lplayer, w_dr, w_dc) >= K;
    w_win_any = r_win | w_hit;
  end

  // Next-state logic and per-cycle accept/error decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE:    w_state_nxt = isPlayer1Start ? S_WAIT_P1 : S_WAIT_P2;
      S_WAIT_P1,
      S_WAIT_P2: begin
        if (playerWrite) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            w_state_nxt = S_CHECK;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (r_dir == 2'd3) begin
          if (w_win_any || r_cnt == CW'(N*N)) w_state_nxt = S_DONE;
          else w_state_nxt = (r_lplayer == C_P1) ? S_WAIT_P2 : S_WAIT_P1;
        end
      end
      S_DONE:    w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ph1) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Board, counters, last-move record, check progress and result registers.
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_board    <= '0;
      r_cnt      <= '0;
      r_winner   <= C_NONE;
      r_move_err <= 1'b0;
      r_dir      <= 2'd0;
      r_win      <= 1'b0;
      r_lrow     <= '0;
      r_lcol     <= '0;
      r_lplayer  <= C_NONE;
    end else begin
      r_move_err <= w_err;
      if (w_accept) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            if (playerRow == RW'(r) && playerCol == RW'(c))
              r_board[2*(r*N+c) +: 2] <= w_mover;
        r_cnt     <= r_cnt + CW'(1);
        r_lrow    <= playerRow;
        r_lcol    <= playerCol;
        r_lplayer <= w_mover;
        r_dir     <= 2'd0;
        r_win     <= 1'b0;
      end
      if (r_state == S_CHECK) begin
        r_dir <= r_dir + 2'd1;
        r_win <= w_win_any;
        // A win outranks a full board, so a winning last move is never a tie.
        if (r_dir == 2'd3) begin
          if (w_win_any)                 r_winner <= r_lplayer;
          else if (r_cnt == CW'(N*N))    r_winner <= C_TIE;
        end
      end
    end
  end

  assign gBoard      = r_board;
  assign outputState = r_state;
  assign gameIsDone  = (r_state == S_DONE);
  assign winner      = r_winner;
  assign moveErr     = r_move_err;
  assign moveCount   = r_cnt;

endmodule

// File: tb/tb_nxn_game_ctrl.sv
// Directed bench for nxn_game_ctrl: a 3x3/K=3 instance and a 5x5/K=4 instance.
// Inputs change and outputs are sampled on the falling edge of ph1.
// Expected values are hand-derived constants for each scripted game.
module tb_nxn_game_ctrl;

  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // 3x3, K=3 instance
  logic        rst3, p1s3, wr3;
  logic [1:0]  row3, col3;
  logic [17:0] board3;
  logic [2:0]  st3;
  logic        done3, err3;
  logic [1:0]  win3;
  logic [3:0]  cnt3;

  // 5x5, K=4 instance
  logic        rst5, p1s5, wr5;
  logic [2:0]  row5, col5;
  logic [49:0] board5;
  logic [2:0]  st5;
  logic        done5, err5;
  logic [1:0]  win5;
  logic [4:0]  cnt5;

  int n_checks = 0;
  int n_errors = 0;

  nxn_game_ctrl #(.N(3), .K(3)) u_dut3 (
    .ph1(ph1), .reset(rst3), .isPlayer1Start(p1s3), .playerWrite(wr3),
    .playerRow(row3), .playerCol(col3), .gBoard(board3), .outputState(st3),
    .gameIsDone(done3), .winner(win3), .moveErr(err3), .moveCount(cnt3)
  );

  nxn_game_ctrl #(.N(5), .K(4)) u_dut5 (
    .ph1(ph1), .reset(rst5), .isPlayer1Start(p1s5), .playerWrite(wr5),
    .playerRow(row5), .playerCol(col5), .gBoard(board5), .outputState(st5),
    .gameIsDone(done5), .winner(win5), .moveErr(err5), .moveCount(cnt5)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge ph1);
  endtask

  // One-cycle write request; returns on the falling edge after the sampling edge.
  task automatic mv3(input int r, input int c);
    wr3 = 1'b1; row3 = 2'(r); col3 = 2'(c);
    @(negedge ph1);
    wr3 = 1'b0;
  endtask

  task automatic mv5(input int r, input int c);
    wr5 = 1'b1; row5 = 3'(r); col5 = 3'(c);
    @(negedge ph1);
    wr5 = 1'b0;
  endtask

  task automatic restart3;
    rst3 = 1'b1; p1s3 = 1'b1;
    @(negedge ph1);
    rst3 = 1'b0;
    @(negedge ph1);
  endtask

  int tie_r[7] = '{0, 1, 1, 1, 2, 2, 2};
  int tie_c[7] = '{2, 1, 0, 2, 1, 0, 2};
  int lw_r[9]  = '{0, 0, 0, 1, 2, 1, 2, 2, 1};
  int lw_c[9]  = '{0, 1, 2, 1, 0, 2, 1, 2, 0};
  int g5_r[7]  = '{0, 0, 1, 4, 2, 4, 3};
  int g5_c[7]  = '{4, 0, 3, 4, 2, 0, 1};

  initial begin
    rst3 = 1'b1; p1s3 = 1'b1; wr3 = 1'b0; row3 = '0; col3 = '0;
    rst5 = 1'b1; p1s5 = 1'b0; wr5 = 1'b0; row5 = '0; col5 = '0;
    wait_n(2);
    chk("rst_state", 64'(st3), 64'h0);
    chk("rst_board", 64'(board3), 64'h0);
    chk("rst_count", 64'(cnt3), 64'h0);
    chk("rst_winner", 64'(win3), 64'h0);
    chk("rst_done", 64'(done3), 64'h0);
    chk("rst_err", 64'(err3), 64'h0);
    rst3 = 1'b0; rst5 = 1'b0;
    @(negedge ph1);
    chk("idle_to_p1", 64'(st3), 64'h1);
    chk("idle_to_p2", 64'(st5), 64'h2);

    // Game A: player1 wins on the top row.
    mv3(0, 0);
    chk("a_check_state", 64'(st3), 64'h3);
    chk("a_board1", 64'(board3), 64'h3);
    chk("a_count1", 64'(cnt3), 64'h1);
    wait_n(4);
    chk("a_to_p2", 64'(st3), 64'h2);
    mv3(1, 0); wait_n(4);
    mv3(0, 1); wait_n(4);
    mv3(1, 1); wait_n(4);
    mv3(0, 2); wait_n(3);
    chk("a_still_check", 64'(st3), 64'h3);
    chk("a_no_early_done", 64'(done3), 64'h0);
    chk("a_winner_00_in_check", 64'(win3), 64'h0);
    wait_n(1);
    chk("a_done_state", 64'(st3), 64'h4);
    chk("a_done", 64'(done3), 64'h1);
    chk("a_winner", 64'(win3), 64'h3);
    chk("a_count", 64'(cnt3), 64'h5);
    chk("a_board", 64'(board3), 64'h2BF);
    mv3(2, 2);
    chk("a_done_write_err", 64'(err3), 64'h0);
    chk("a_done_write_board", 64'(board3), 64'h2BF);
    wait_n(2);
    chk("a_done_hold_state", 64'(st3), 64'h4);
    chk("a_done_hold_winner", 64'(win3), 64'h3);
    chk("a_done_hold_count", 64'(cnt3), 64'h5);

    // Game B: illegal moves, a write during CHECK, then a full-board tie.
    restart3();
    mv3(0, 0); wait_n(4);
    mv3(0, 0);
    chk("b_occ_err", 64'(err3), 64'h1);
    chk("b_occ_board", 64'(board3), 64'h3);
    chk("b_occ_count", 64'(cnt3), 64'h1);
    chk("b_occ_state", 64'(st3), 64'h2);
    wait_n(1);
    chk("b_occ_err_clear", 64'(err3), 64'h0);
    mv3(3, 1);
    chk("b_row_err", 64'(err3), 64'h1);
    chk("b_row_board", 64'(board3), 64'h3);
    chk("b_row_count", 64'(cnt3), 64'h1);
    chk("b_row_state", 64'(st3), 64'h2);
    wait_n(1);
    chk("b_row_err_clear", 64'(err3), 64'h0);
    mv3(1, 3);
    chk("b_col_err", 64'(err3), 64'h1);
    wait_n(1);
    mv3(0, 1);
    mv3(2, 2);
    chk("b_check_write_err", 64'(err3), 64'h0);
    chk("b_check_write_board", 64'(board3), 64'hB);
    wait_n(3);
    chk("b_to_p1", 64'(st3), 64'h1);
    for (int i = 0; i < 7; i++) begin
      mv3(tie_r[i], tie_c[i]);
      wait_n(4);
    end
    chk("b_tie_state", 64'(st3), 64'h4);
    chk("b_tie_winner", 64'(win3), 64'h1);
    chk("b_tie_count", 64'(cnt3), 64'h9);
    chk("b_tie_board", 64'(board3), 64'h3EAFB);

    // Game C: player1 completes a column with the ninth move.
    restart3();
    for (int i = 0; i < 9; i++) begin
      mv3(lw_r[i], lw_c[i]);
      wait_n(4);
    end
    chk("c_lastwin_state", 64'(st3), 64'h4);
    chk("c_lastwin_winner", 64'(win3), 64'h3);
    chk("c_lastwin_count", 64'(cnt3), 64'h9);

    // Game D: reset together with a write on the second CHECK cycle.
    restart3();
    mv3(1, 1);
    @(negedge ph1);
    rst3 = 1'b1; wr3 = 1'b1; row3 = 2'd2; col3 = 2'd2;
    @(negedge ph1);
    chk("d_rst_state", 64'(st3), 64'h0);
    chk("d_rst_board", 64'(board3), 64'h0);
    chk("d_rst_count", 64'(cnt3), 64'h0);
    chk("d_rst_winner", 64'(win3), 64'h0);
    chk("d_rst_err", 64'(err3), 64'h0);
    rst3 = 1'b0; wr3 = 1'b0;
    @(negedge ph1);
    chk("d_restart_p1", 64'(st3), 64'h1);

    // 5x5, K=4: player2 wins on the anti-diagonal.
    for (int i = 0; i < 7; i++) begin
      mv5(g5_r[i], g5_c[i]);
      wait_n(4);
      if (i == 4) chk("g5_three_no_win", 64'(st5), 64'h1);
    end
    chk("g5_state", 64'(st5), 64'h4);
    chk("g5_done", 64'(done5), 64'h1);
    chk("g5_winner", 64'(win5), 64'h2);
    chk("g5_count", 64'(cnt5), 64'h7);
    chk("g5_err", 64'(err5), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nxn_game_ctrl.md
NXN_GAME_CTRL -- requirements
Module: nxn_game_ctrl

Interface
REQ-001 Parameter N, default 3: board dimension (3..8); the board holds N*N cells.
REQ-002 Parameter K, default 3: number of marks in a line needed to win (3..N).
REQ-003 Parameter derived RW = $clog2(N) (minimum 1): width of the row and column fields.
REQ-004 ph1  input  1  sole clock; all state updates occur on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 isPlayer1Start  input  1  1 = player1 moves first; sampled only in IDLE.
REQ-007 playerWrite  input  1  one-cycle move request.
REQ-008 playerRow, playerCol  input  RW each  target cell of the move.
REQ-009 gBoard  output  2*N*N  cell (r,c) occupies bits [2*(r*N+c)+1 : 2*(r*N+c)]; encoding: empty 00, player1 11, player2 10.
REQ-010 outputState  output  3  current FSM state encoding.
REQ-011 gameIsDone  output  1  high iff the FSM is in DONE.
REQ-012 winner  output  2  result: player1 11, player2 10, tie 01, no result 00.
REQ-013 moveErr  output  1  one-cycle pulse flagging a rejected move.
REQ-014 moveCount  output  $clog2(N*N+1)  number of accepted moves.

Function
REQ-015 The FSM states and their outputState codes SHALL be: IDLE 000, WAIT_P1 001, WAIT_P2 010, CHECK 011, DONE 100.
REQ-016 From IDLE, the FSM SHALL move after exactly one cycle to WAIT_P1 if isPlayer1Start=1, otherwise to WAIT_P2.
REQ-017 In WAIT_Px, a legal move SHALL be accepted. A legal move means: playerWrite=1, row<N, col<N, and the target cell is 00.
REQ-018 On the accepting edge, the module SHALL, all on that edge: write the player code to the target cell, increment moveCount, latch row/col/player as the last-move registers, and enter CHECK.
REQ-019 In WAIT_Px, an illegal move (playerWrite=1 with an occupied cell, row>=N or col>=N) SHALL cause the following on the next edge:
- moveErr=1 for exactly one cycle;
- board, moveCount and state unchanged.
REQ-020 moveErr SHALL be 0 in every other cycle.
REQ-021 playerWrite SHALL be ignored in IDLE, CHECK and DONE: no write, and no moveErr.
REQ-022 CHECK SHALL last exactly 4 cycles, using an internal direction counter. The directions are horizontal, vertical, diagonal (r+1,c+1) and anti-diagonal (r+1,c-1), one per cycle.
REQ-023 In each CHECK cycle, the module SHALL count the contiguous cells holding the last mover's code along that direction through the last move, in both senses, bounded by the board edges.
REQ-024 A run length >= K in any direction SHALL set a sticky win flag for the check.
REQ-025 On the 4th CHECK edge, with a win: the FSM SHALL go to DONE with winner = mover code (11 or 10).
REQ-026 On the 4th CHECK edge, with no win and moveCount==N*N: the FSM SHALL go to DONE with winner=01.
REQ-027 On the 4th CHECK edge, otherwise: the FSM SHALL go to WAIT of the other player.
REQ-028 A win on the final (N*N-th) move SHALL report the winner, not a tie.
REQ-029 Timing: a move accepted at edge E0 SHALL give a DONE/WAIT transition at edge E4; the earliest next accepted move SHALL be at edge E5.
REQ-030 DONE SHALL hold the board, winner and moveCount until reset.
REQ-031 gameIsDone SHALL be exactly (state==DONE).
REQ-032 winner SHALL be 00 in every state except DONE.
REQ-033 All outputs SHALL be registered or decoded from registers only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-034 While reset=1 at a rising edge, the module SHALL clear, on that edge: state to IDLE, all cells to 00, moveCount to 0, winner to 00, moveErr to 0, the direction counter, the win flag and the last-move registers.
REQ-035 Reset SHALL take priority over every other event, including a simultaneous playerWrite and reset asserted mid-CHECK.

Verification
REQ-036 N=3,K=3, p1 first; moves (0,0),(1,0),(0,1),(1,1),(0,2) -> gameIsDone=1, winner=11, outputState=100, moveCount=5, 4 cycles after the last accept.
REQ-037 N=3,K=3, nine alternating moves filling the board with no line -> winner=01 after the 9th move's CHECK, moveCount=9.
REQ-038 Writes to an occupied cell and to row=3 (N=3) -> one-cycle moveErr=1 each; gBoard and moveCount unchanged; state stays WAIT_Px.
REQ-039 N=5,K=4, p2 first; p2 marks (0,4),(1,3),(2,2),(3,1) with p1 elsewhere -> anti-diagonal win, winner=10.
REQ-040 Reset asserted on the 2nd CHECK cycle -> next cycle: outputState=000, gBoard all 0, moveCount=0, winner=00.
REQ-041 playerWrite pulsed during CHECK and during DONE -> no board change, moveErr stays 0.
